// File: rtl/cpu_pkg.sv
// Shared LEGv8 CPU widths, register-number constants and data types.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH     = 64;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS       = 32;

  typedef logic [DATA_WIDTH-1:0]     word_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  localparam reg_addr_t XZR      = 5'd31;
  localparam reg_addr_t LINK_REG = 5'd30;

endpackage

// File: rtl/wb_reg_file_reg_word.sv
// One architectural register: load-enabled flop word with asynchronous clear.
module reg_word #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/wb_reg_file.sv
// LEGv8 architectural register file: write-back port, two decode read ports
// with same-cycle write-to-read bypass; XZR has no storage and reads as zero.
module wb_reg_file #(
  parameter int unsigned DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int unsigned NUM_REGS   = cpu_pkg::NUM_REGS,
  parameter int unsigned ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH,
  parameter int unsigned ZERO_REG   = 32'(cpu_pkg::XZR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  import cpu_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ZR_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
  logic                  w_wr_live;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  // A write is architecturally live only out of reset and when not aimed at XZR.
  assign w_wr_live = !reset && RegWrite && (WriteRegister != ZR_ADDR);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    if (gi == ZERO_REG) begin : g_zero
      assign w_regs[gi] = '0;
    end else begin : g_word
      logic w_en;
      assign w_en = w_wr_live && (WriteRegister == ADDR_WIDTH'(gi));
      reg_word #(.WIDTH(DATA_WIDTH)) u_word (
        .clk  (clk),
        .rst  (reset),
        .i_en (w_en),
        .i_d  (WriteData),
        .o_q  (w_regs[gi])
      );
    end
  end

  // Port 1: XZR first, then bypass of the in-flight write, then storage.
  always_comb begin
    w_rd1 = '0;
    if (reset || (ReadRegister1 == ZR_ADDR)) begin
      w_rd1 = '0;
    end else if (w_wr_live && (WriteRegister == ReadRegister1)) begin
      w_rd1 = WriteData;
    end else begin
      w_rd1 = w_regs[ReadRegister1];
    end
  end

  // Port 2: identical priority to port 1.
  always_comb begin
    w_rd2 = '0;
    if (reset || (ReadRegister2 == ZR_ADDR)) begin
      w_rd2 = '0;
    end else if (w_wr_live && (WriteRegister == ReadRegister2)) begin
      w_rd2 = WriteData;
    end else begin
      w_rd2 = w_regs[ReadRegister2];
    end
  end

  assign ReadData1 = w_rd1;
  assign ReadData2 = w_rd2;

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed scoreboard bench for wb_reg_file: expected read pairs are queued
// as stimulus is driven and popped when the combinational outputs settle.
module tb_wb_reg_file;
  import cpu_pkg::*;

  logic      clk;
  logic      reset;
  logic      RegWrite;
  reg_addr_t WriteRegister;
  word_t     WriteData;
  reg_addr_t ReadRegister1;
  reg_addr_t ReadRegister2;
  word_t     ReadData1;
  word_t     ReadData2;

  typedef struct {
    string tag;
    word_t e1;
    word_t e2;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp = 0;
  int   n_err = 0;

  wb_reg_file dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach summary (time %0t)", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string tag, input word_t e1, input word_t e2);
    exp_t e;
    e.tag = tag;
    e.e1  = e1;
    e.e2  = e2;
    q_exp.push_back(e);
  endtask

  // Let the combinational read path settle, then compare against the oldest entry.
  task automatic check_rd();
    exp_t e;
    #1;
    n_cmp++;
    assert (q_exp.size() > 0) else begin
      n_err++;
      $error("FAIL scoreboard_empty: got queue size %0d want >0", q_exp.size());
    end
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      n_cmp++;
      assert (ReadData1 === e.e1) else begin
        n_err++;
        $error("FAIL %s rd1: got %h want %h", e.tag, ReadData1, e.e1);
      end
      n_cmp++;
      assert (ReadData2 === e.e2) else begin
        n_err++;
        $error("FAIL %s rd2: got %h want %h", e.tag, ReadData2, e.e2);
      end
    end
  endtask

  task automatic rd(input string tag, input reg_addr_t a1, input reg_addr_t a2,
                    input word_t e1, input word_t e2);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    push_exp(tag, e1, e2);
    check_rd();
  endtask

  task automatic set_wr(input logic we, input reg_addr_t wa, input word_t wd);
    RegWrite      = we;
    WriteRegister = wa;
    WriteData     = wd;
  endtask

  initial begin
    reset = 1'b1;
    set_wr(1'b0, '0, '0);
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    repeat (2) @(negedge clk);
    rd("por_x0", 5'd0, 5'd1, 64'h0, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    rd("post_por", 5'd5, 5'd30, 64'h0, 64'h0);

    // Plain write then read, untouched neighbour stays zero
    set_wr(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0005);
    @(negedge clk);
    set_wr(1'b0, 5'd0, '0);
    rd("wr_x5", 5'd5, 5'd6, 64'hDEAD_BEEF_0000_0005, 64'h0);

    // Same-cycle bypass on both ports, then stored value
    set_wr(1'b1, 5'd9, 64'h1234);
    rd("bypass_x9", 5'd9, 5'd9, 64'h1234, 64'h1234);
    @(negedge clk);
    set_wr(1'b0, 5'd0, '0);
    rd("stored_x9", 5'd9, 5'd9, 64'h1234, 64'h1234);

    // RegWrite=0 with matching address: no bypass, no write
    set_wr(1'b0, 5'd9, 64'hFFFF);
    rd("nowr_pre", 5'd9, 5'd5, 64'h1234, 64'hDEAD_BEEF_0000_0005);
    @(negedge clk);
    rd("nowr_post", 5'd9, 5'd9, 64'h1234, 64'h1234);

    // XZR: write discarded, never bypassed
    set_wr(1'b1, XZR, 64'hFFFF_FFFF_FFFF_FFFF);
    rd("xzr_pre", XZR, XZR, 64'h0, 64'h0);
    @(negedge clk);
    set_wr(1'b0, 5'd0, '0);
    rd("xzr_post", XZR, 5'd9, 64'h0, 64'h1234);

    // BL link write
    set_wr(1'b1, LINK_REG, 64'h0000_0000_0000_0104);
    rd("bl_bypass", 5'd0, LINK_REG, 64'h0, 64'h104);
    @(negedge clk);
    set_wr(1'b0, 5'd0, '0);
    rd("bl_stored", 5'd0, LINK_REG, 64'h0, 64'h104);

    // Fill X0..X30 with i+1, then read back from both ports
    for (int i = 0; i < 31; i++) begin
      set_wr(1'b1, 5'(i), 64'(i + 1));
      @(negedge clk);
    end
    set_wr(1'b0, 5'd0, '0);
    for (int i = 0; i < 31; i++) begin
      rd($sformatf("fill_x%0d", i), 5'(i), 5'(30 - i), 64'(i + 1), 64'(31 - i));
    end
    rd("fill_xzr", XZR, 5'd0, 64'h0, 64'h1);

    // Asynchronous reset mid-cycle with a write pending: bypass suppressed
    @(posedge clk);
    #2;
    set_wr(1'b1, 5'd3, 64'h5555);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd($sformatf("rst_hi_x%0d", i), 5'(i), 5'(31 - i), 64'h0, 64'h0);
    end
    @(negedge clk);
    set_wr(1'b0, 5'd0, '0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd($sformatf("rst_lo_x%0d", i), 5'(i), 5'(31 - i), 64'h0, 64'h0);
    end

    // Reset released mid-cycle: first write lands at the next rising edge
    @(negedge clk);
    reset = 1'b1;
    #2;
    set_wr(1'b1, 5'd7, 64'h77);
    reset = 1'b0;
    rd("rel_bypass", 5'd7, 5'd8, 64'h77, 64'h0);
    @(negedge clk);
    set_wr(1'b0, 5'd0, '0);
    rd("rel_write", 5'd7, 5'd7, 64'h77, 64'h77);

    n_cmp++;
    assert (q_exp.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain: got %0d leftover want 0", q_exp.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
